// File: rtl/pq_deadline_dispatch.sv
// pq_deadline_dispatch: pops expired deadline words from pq into a 2-entry output FIFO and flags late dispatches
package pq_pkg;
  parameter int DATA_WIDTH = 8;
endpackage

module pq_deadline_dispatch #(
  parameter int DW = pq_pkg::DATA_WIDTH,
  parameter int LATE_THR = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             tick_i,
  output logic [DW-1:0]    time_o,
  input  logic             peek_vld_i,
  input  logic [DW-1:0]    peek_data_i,
  output logic             pop_o,
  input  logic             pop_rdy_i,
  input  logic [DW-1:0]    pq_data_i,
  output logic             out_vld_o,
  input  logic             out_rdy_i,
  output logic [DW-1:0]    out_data_o,
  output logic             late_o,
  output logic [CNT_W-1:0] late_cnt_o
);
  typedef enum logic {S_IDLE, S_POP} state_t;
  state_t r_state, w_next;
  logic [DW-1:0] r_now;
  logic [DW-1:0] r_mem [2];
  logic r_wp, r_rp;
  logic [1:0] r_cnt;
  logic r_late;
  logic [CNT_W-1:0] r_late_cnt;
  logic [DW-1:0] w_age, w_lat;
  logic w_exp, w_xfer, w_rd, w_late;

  // the head is dispatchable when enabled, valid and its deadline is not in the future (modular)
  assign w_age  = r_now - peek_data_i;
  assign w_exp  = en_i && peek_vld_i && !w_age[DW-1];
  assign w_xfer = (r_state == S_POP) && pop_rdy_i;
  assign w_rd   = (r_cnt != 2'd0) && out_rdy_i;
  assign w_lat  = r_now - pq_data_i;
  assign w_late = w_xfer && (w_lat > DW'(LATE_THR));

  assign time_o     = r_now;
  assign pop_o      = (r_state == S_POP);
  assign out_vld_o  = (r_cnt != 2'd0);
  assign out_data_o = r_mem[r_rp];
  assign late_o     = r_late;
  assign late_cnt_o = r_late_cnt;

  // next state: pop only with a free slot; leave POP on transfer or when the head stops being dispatchable
  always_comb begin
    w_next = r_state;
    w_next = (r_state == S_IDLE) ? ((w_exp && r_cnt < 2'd2) ? S_POP : S_IDLE)
                                 : ((pop_rdy_i || !w_exp) ? S_IDLE : S_POP);
  end

  // state register, time base and lateness tracking
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= S_IDLE;
      r_now      <= '0;
      r_late     <= 1'b0;
      r_late_cnt <= '0;
    end else begin
      r_state <= w_next;
      r_now   <= r_now + DW'(tick_i);
      r_late  <= w_late;
      if (w_late && !(&r_late_cnt)) r_late_cnt <= r_late_cnt + 1'b1;
    end
  end

  // 2-entry output FIFO; write on pop transfer, read on output handshake
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wp     <= 1'b0;
      r_rp     <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (w_xfer) r_mem[r_wp] <= pq_data_i;
      r_wp  <= r_wp ^ w_xfer;
      r_rp  <= r_rp ^ w_rd;
      r_cnt <= r_cnt + 2'(w_xfer) - 2'(w_rd);
    end
  end
endmodule
